// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 Hz VGA raster generator.
package vga_pkg;

  // Coordinate width used for both row and column counters.
  localparam int COORD_W = 10;

  // Default 640x480@60 Hz timing, horizontal in pixels, vertical in lines.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 3-bit colour, one bit each for R, G and B.
  typedef logic [2:0] rgb_t;

  // True when a coordinate lies inside the inclusive window [lo, hi].
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around counter for one raster axis. Advances on en, returns to zero
// after TOTAL-1; wrap is high while en is high at the terminal count so it
// can directly enable the next axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = VGA_H_TOTAL,
  parameter int W     = COORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_r;

  assign count = count_r;
  assign wrap  = en && (count_r == LAST);

  // Axis position: clears on reset, steps on en, wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing and final pixel output stage for the Pong display.
// Optional build macro: VGA_TEST_PATTERN_EN adds a pattern_sel input that
// replaces the component colour with colour bars (col[9:7]) when set.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   CLK_DIV     = 2,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  input  rgb_t               rgb_in,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               pix_en,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output rgb_t               rgb_out,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_ACT_C    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_LO      = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI      = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_LO      = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI      = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_ACTIVE - 1);

  // Counters are COORD_W bits wide, so larger rasters cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   div_r;
  logic               pix_en_s;
  logic [COORD_W-1:0] col_s;
  logic [COORD_W-1:0] row_s;
  logic               h_wrap_s;
  logic               v_wrap_unused_s;
  logic               video_on_s;
  logic               frame_end_s;
  rgb_t               rgb_src_s;
  logic               hsync_r;
  logic               vsync_r;
  rgb_t               rgb_r;
  logic               frame_tick_r;

  // Pixel-rate divider: counts 0..CLK_DIV-1 and strobes on the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Held low during reset so a CLK_DIV of 1 does not strobe while in reset.
  assign pix_en_s = (div_r == DIV_LAST) && !reset;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(COORD_W)) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en_s),
    .count (col_s),
    .wrap  (h_wrap_s)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(COORD_W)) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap_s),
    .count (row_s),
    .wrap  (v_wrap_unused_s)
  );

  assign video_on_s  = (col_s < H_ACT_C) && (row_s < V_ACT_C);
  assign frame_end_s = pix_en_s && (col_s == H_LAST) && (row_s == V_ACT_LAST);

  // Colour source for the output stage: components or built-in colour bars.
  always_comb begin
    rgb_src_s = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      rgb_src_s = rgb_t'(col_s[9:7]);
    end else begin
      rgb_src_s = rgb_in;
    end
`endif
  end

  // Output stage: sync and blanked colour registered together, one pixel late.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_r <= ~SYNC_ACTIVE;
      vsync_r <= ~SYNC_ACTIVE;
      rgb_r   <= 3'b000;
    end else if (pix_en_s) begin
      hsync_r <= in_window(col_s, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_r <= in_window(row_s, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_r   <= video_on_s ? rgb_src_s : 3'b000;
    end
  end

  // Frame tick: one clk pulse after the last visible pixel of the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= frame_end_s;
    end
  end

  assign col        = col_s;
  assign row        = row_s;
  assign pix_en     = pix_en_s;
  assign video_on   = video_on_s;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign rgb_out    = rgb_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing. Two instances share stimulus: A uses the
// full 640x480 timing, B keeps the horizontal timing but a 13-line frame so
// several whole frames fit in a short run.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int D    = 2;
  localparam int HT   = 800;
  localparam int VA_A = 480;
  localparam int VF_A = 10;
  localparam int VS_A = 2;
  localparam int VT_A = 525;
  localparam int VA_B = 6;
  localparam int VF_B = 2;
  localparam int VS_B = 2;
  localparam int VT_B = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rgb_t rgb_in = 3'b000;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  logic [9:0] col_a, row_a, col_b, row_b;
  logic pix_en_a, video_on_a, hsync_a, vsync_a, frame_tick_a;
  logic pix_en_b, video_on_b, hsync_b, vsync_b, frame_tick_b;
  rgb_t rgb_out_a, rgb_out_b;

  vga_timing #(.CLK_DIV(D)) dut_a (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rgb_in(rgb_in), .col(col_a), .row(row_a), .pix_en(pix_en_a),
    .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a),
    .rgb_out(rgb_out_a), .frame_tick(frame_tick_a)
  );

  vga_timing #(.CLK_DIV(D), .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(3)) dut_b (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rgb_in(rgb_in), .col(col_b), .row(row_b), .pix_en(pix_en_b),
    .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b),
    .rgb_out(rgb_out_b), .frame_tick(frame_tick_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model state: k = clock edges since reset was last sampled low,
  // cap = colour latched at the most recent pixel strobe.
  int   k = 0;
  bit   started = 1'b0;
  rgb_t cap = 3'b000;

  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      started = 1'b1;
    end else begin
      if (k % D == D - 1) begin
        cap = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) cap = rgb_t'((((k / D) % HT) >> 7) & 7);
`endif
      end
      k = k + 1;
    end
  end

  function automatic bit in_rng(input int v, input int lo, input int n);
    return (v >= lo) && (v < lo + n);
  endfunction

  // Compare one instance against the arithmetic raster model.
  task automatic cmp_inst(input string tag, input int va, input int vfp, input int vsw,
                          input int vt, input logic [9:0] c, input logic [9:0] r,
                          input logic pe, input logic vo, input logic hs,
                          input logic vs, input rgb_t rgb, input logic ft);
    int p, q, qc, qr;
    logic ehs, evs, eft;
    rgb_t ergb;
    p = k / D;
    chk({tag, ".col"}, 32'(c), 32'(p % HT));
    chk({tag, ".row"}, 32'(r), 32'((p / HT) % vt));
    chk({tag, ".pix_en"}, 32'(pe), 32'(!reset && (k % D == D - 1)));
    chk({tag, ".video_on"}, 32'(vo), 32'(((p % HT) < 640) && (((p / HT) % vt) < va)));
    if (p == 0) begin
      ehs = 1'b1; evs = 1'b1; ergb = 3'b000; eft = 1'b0;
    end else begin
      q    = p - 1;
      qc   = q % HT;
      qr   = (q / HT) % vt;
      ehs  = !in_rng(qc, 640 + 16, 96);
      evs  = !in_rng(qr, va + vfp, vsw);
      ergb = (qc < 640 && qr < va) ? cap : 3'b000;
      eft  = (k % D == 0) && ((q % (HT * vt)) == (va - 1) * HT + HT - 1);
    end
    chk({tag, ".hsync"}, 32'(hs), 32'(ehs));
    chk({tag, ".vsync"}, 32'(vs), 32'(evs));
    chk({tag, ".rgb_out"}, 32'(rgb), 32'(ergb));
    chk({tag, ".frame_tick"}, 32'(ft), 32'(eft));
  endtask

  // Every-cycle comparison of both instances, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      cmp_inst("A", VA_A, VF_A, VS_A, VT_A, col_a, row_a, pix_en_a, video_on_a,
               hsync_a, vsync_a, rgb_out_a, frame_tick_a);
      cmp_inst("B", VA_B, VF_B, VS_B, VT_B, col_b, row_b, pix_en_b, video_on_b,
               hsync_b, vsync_b, rgb_out_b, frame_tick_b);
    end
  end

  // Event counters used by the hand-computed checks of the first run.
  bit phase1 = 1'b0;
  int cnt_hs_a = 0, cnt_rgb7_a = 0, cnt_vs_b = 0, ft_double = 0;
  int ft_k[$];
  logic prev_ft_b = 1'b0;

  always @(negedge clk) begin
    if (phase1) begin
      if (k >= 2 && k < 1602 && hsync_a == 1'b0) cnt_hs_a++;
      if (k >= 3202 && k < 4802 && rgb_out_a == 3'b111) cnt_rgb7_a++;
      if (k >= 2 && k < 20802 && vsync_b == 1'b0) cnt_vs_b++;
      if (frame_tick_b) begin
        ft_k.push_back(k);
        if (prev_ft_b) ft_double++;
      end
      prev_ft_b = frame_tick_b;
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst.hsync", 32'(hsync_a), 32'd1);
    chk("rst.vsync", 32'(vsync_a), 32'd1);
    chk("rst.rgb_out", 32'(rgb_out_a), 32'd0);
    chk("rst.frame_tick", 32'(frame_tick_a), 32'd0);
    chk("rst.video_on", 32'(video_on_a), 32'd1);
    chk("rst.col", 32'(col_a), 32'd0);
    reset = 1'b0;
    phase1 = 1'b1;
    @(posedge clk); #1;
    chk("first.pix_en", 32'(pix_en_a), 32'd1);
    chk("first.col0", 32'(col_a), 32'd0);
    @(posedge clk); #1;
    chk("first.col1", 32'(col_a), 32'd1);

    // Random colour, with a constant white window covering visible line 2 of A.
    while (k < 41000) begin
      if (k >= 2800 && k < 5200) rgb_in = 3'b111;
      else rgb_in = rgb_t'($urandom_range(7, 0));
`ifdef VGA_TEST_PATTERN_EN
      pattern_sel = (k >= 2800 && k < 5200) ? 1'b0 : 1'($urandom_range(1, 0));
`endif
      @(posedge clk); #1;
    end
    phase1 = 1'b0;
    chk("line.hsync_low_clks", 32'(cnt_hs_a), 32'd192);
    chk("line.white_clks", 32'(cnt_rgb7_a), 32'd1280);
    chk("frame.vsync_low_clks", 32'(cnt_vs_b), 32'd3200);
    chk("frame.tick_count", 32'(ft_k.size()), 32'd2);
    if (ft_k.size() >= 2) begin
      chk("frame.tick_first", 32'(ft_k[0]), 32'd9600);
      chk("frame.tick_period", 32'(ft_k[1] - ft_k[0]), 32'd20800);
    end
    chk("frame.tick_width", 32'(ft_double), 32'd0);

    // Reset mid-line while hsync is asserted.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clk); #1;
      if (col_a == 10'd700 && hsync_a == 1'b0) found = 1'b1;
    end
    chk("midrst.found", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.hsync", 32'(hsync_a), 32'd1);
    chk("midrst.col", 32'(col_a), 32'd0);
    chk("midrst.row", 32'(row_a), 32'd0);
    chk("midrst.frame_tick", 32'(frame_tick_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3000) begin
      rgb_in = rgb_t'($urandom_range(7, 0));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
